// File: rtl/covariance_matrix_pkg.sv
// covariance_matrix_pkg: shared fixed-point types, FSM states and the saturating shift helper
package covariance_matrix_pkg;
  localparam int WIDTH = 16;
  localparam int DEF_FRAC = 8;
  localparam int N_STOCKS = 4;
  localparam int DEF_LOG2_SAMPLES = 2;
  typedef logic signed [WIDTH-1:0] sample_t;
  typedef logic [N_STOCKS-1:0][WIDTH-1:0] stock_vec_t;
  typedef logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] matrix_t;
  typedef enum logic [1:0] {IDLE, ACCUM, COMPUTE, DONE} state_t;
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] value, input int shift, input int width);
    logic signed [63:0] s, hi;
    s = value >>> shift;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    return s > hi ? hi : s < -hi - 64'sd1 ? -hi - 64'sd1 : s;
  endfunction
endpackage

// File: rtl/covariance_matrix_if.sv
// covariance_matrix_if: sample stream in, covariance matrix bus and status out
interface covariance_matrix_if import covariance_matrix_pkg::*;;
  logic start, in_valid, in_ready, busy, done;
  stock_vec_t in_data;
  matrix_t matrix;
  modport master(output start, in_valid, in_data, input in_ready, busy, done, matrix);
  modport slave(input start, in_valid, in_data, output in_ready, busy, done, matrix);
endinterface

// File: rtl/covariance_matrix_cov_entry.sv
// cov_entry: one saturated covariance entry from the window sums of a stock pair
module cov_entry import covariance_matrix_pkg::*; #(
  parameter int FRAC = DEF_FRAC,
  parameter int LOG2_SAMPLES = DEF_LOG2_SAMPLES
) (
  input  logic signed [2*WIDTH+LOG2_SAMPLES-1:0] sum_xy,
  input  logic signed [WIDTH+LOG2_SAMPLES-1:0]   sum_x_i,
  input  logic signed [WIDTH+LOG2_SAMPLES-1:0]   sum_x_j,
  output sample_t                                 entry
);
  localparam int EW = 2 * WIDTH + 1;
  sample_t mu_i, mu_j;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH+LOG2_SAMPLES-1:0] mean_xy;
  logic signed [EW-1:0] e;
  always_comb begin
    mu_i = WIDTH'(sum_x_i >>> LOG2_SAMPLES);
    mu_j = WIDTH'(sum_x_j >>> LOG2_SAMPLES);
    prod = mu_i * mu_j;
    mean_xy = sum_xy >>> LOG2_SAMPLES;
    e = EW'(mean_xy) - EW'(prod);
    entry = WIDTH'(sat_shift(64'(e), FRAC, WIDTH));
  end
endmodule

// File: rtl/covariance_matrix.sv
// covariance_matrix: accumulates a window of return vectors, then builds the covariance matrix
// one upper-triangle entry per cycle through a single shared datapath.
module covariance_matrix import covariance_matrix_pkg::*; #(
  parameter int FRAC = DEF_FRAC,
  parameter int LOG2_SAMPLES = DEF_LOG2_SAMPLES
) (
  input logic clk,
  input logic rst,
  covariance_matrix_if.slave bus
);
  localparam int SW = WIDTH + LOG2_SAMPLES;
  localparam int PW = 2 * WIDTH + LOG2_SAMPLES;
  localparam int IW = $clog2(N_STOCKS);
  localparam logic [IW-1:0] LAST = IW'(N_STOCKS - 1);
  state_t state_q, state_d;
  logic in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d;
  logic [LOG2_SAMPLES-1:0] cnt_q, cnt_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d;
  logic signed [SW-1:0] sum_x_q [N_STOCKS], sum_x_d [N_STOCKS];
  logic signed [PW-1:0] sum_xy_q [N_STOCKS][N_STOCKS], sum_xy_d [N_STOCKS][N_STOCKS];
  matrix_t matrix_q, matrix_d;
  sample_t entry;
  cov_entry #(.FRAC(FRAC), .LOG2_SAMPLES(LOG2_SAMPLES)) u_entry (
    .sum_xy(sum_xy_q[i_q][j_q]),
    .sum_x_i(sum_x_q[i_q]),
    .sum_x_j(sum_x_q[j_q]),
    .entry(entry)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    i_d = i_q;
    j_d = j_q;
    sum_x_d = sum_x_q;
    sum_xy_d = sum_xy_q;
    matrix_d = matrix_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = ACCUM;
        cnt_d = '0;
        i_d = '0;
        j_d = '0;
        for (int a = 0; a < N_STOCKS; a++) begin
          sum_x_d[a] = '0;
          for (int b = 0; b < N_STOCKS; b++) sum_xy_d[a][b] = '0;
        end
      end
      ACCUM: if (bus.in_valid) begin
        for (int a = 0; a < N_STOCKS; a++) begin
          sum_x_d[a] = sum_x_q[a] + SW'($signed(bus.in_data[a]));
          for (int b = 0; b < N_STOCKS; b++)
            if (b >= a) sum_xy_d[a][b] = sum_xy_q[a][b] + PW'($signed(bus.in_data[a])) * PW'($signed(bus.in_data[b]));
        end
        cnt_d = cnt_q + 1'b1;
        state_d = &cnt_q ? COMPUTE : ACCUM;
      end
      COMPUTE: begin
        matrix_d[i_q][j_q] = entry;
        matrix_d[j_q][i_q] = entry;
        state_d = (i_q == LAST && j_q == LAST) ? DONE : COMPUTE;
        i_d = j_q == LAST ? i_q + 1'b1 : i_q;
        j_d = j_q == LAST ? i_q + 1'b1 : j_q + 1'b1;
      end
      DONE: begin
        done_d = 1'b1;
        state_d = IDLE;
      end
    endcase
    in_ready_d = state_d == ACCUM;
    busy_d = state_d == ACCUM || state_d == COMPUTE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      in_ready_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q <= '0;
      i_q <= '0;
      j_q <= '0;
      sum_x_q <= '{default: '0};
      sum_xy_q <= '{default: '{default: '0}};
      matrix_q <= '0;
    end else begin
      state_q <= state_d;
      in_ready_q <= in_ready_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q <= cnt_d;
      i_q <= i_d;
      j_q <= j_d;
      sum_x_q <= sum_x_d;
      sum_xy_q <= sum_xy_d;
      matrix_q <= matrix_d;
    end
  assign bus.in_ready = in_ready_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.matrix = matrix_q;
endmodule
